// File: rtl/fsm_while_if.sv
// Handshake bundle between the while-loop controller, its parent and its
// condition/body child groups.
interface fsm_while_if;
    logic valid;
    logic ready;
    logic valid_cond;
    logic ready_cond;
    logic cond_in;
    logic valid_body;
    logic ready_body;

    // Controller side: answers the parent and enables the children.
    modport master (
        input  valid,
        output ready,
        output valid_cond,
        input  ready_cond,
        input  cond_in,
        output valid_body,
        input  ready_body
    );

    // Environment side: parent plus condition and body groups.
    modport slave (
        output valid,
        input  ready,
        input  valid_cond,
        output ready_cond,
        output cond_in,
        input  valid_body,
        output ready_body
    );
endinterface

// File: rtl/fsm_while_ctrl.sv
// While-loop controller: alternates a condition group and a body group over
// valid/ready handshakes until the condition is 0 or MAX_ITER bodies have run.
module fsm_while_ctrl #(
    parameter int CNT_WIDTH = 8,
    parameter int MAX_ITER  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    fsm_while_if.master          bus,
    output logic [CNT_WIDTH-1:0] iter_count,
    output logic                 overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COND = 2'd1,
        BODY = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_ITER);

    if (MAX_ITER < 0 || (CNT_WIDTH < 31 && MAX_ITER >= (1 << CNT_WIDTH))) begin : g_bad_max_iter
        $error("fsm_while_ctrl: MAX_ITER must lie in [0, 2**CNT_WIDTH)");
    end

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] iter_q, iter_d;
    logic                 ovf_q, ovf_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            iter_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    state_d = COND;
                    iter_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            COND: begin
                if (bus.ready_cond) begin
                    if (!bus.cond_in) begin
                        state_d = DONE;
                    end else if ((MAX_ITER != 0) && (iter_q == MAX_C)) begin
                        state_d = DONE;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = BODY;
                    end
                end
            end
            BODY: begin
                // Counter wraps freely; only reachable when the loop is unbounded.
                if (bus.ready_body) begin
                    state_d = COND;
                    iter_d  = iter_q + 1'b1;
                end
            end
            DONE: begin
                if (!bus.valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs: each enable is decoded from exactly one state.
    assign bus.valid_cond = (state_q == COND);
    assign bus.valid_body = (state_q == BODY);
    assign bus.ready      = (state_q == DONE);
    assign iter_count     = iter_q;
    assign overflow       = ovf_q;

endmodule

// File: doc/fsm_while_ctrl.md
# fsm_while_ctrl

Loop controller for generated control logic. It sequences a condition group and a body group through the same valid/ready handshake used by the enable and seq controllers. Each round, it enables the condition group and samples its 1-bit result. If the result is 1, it enables the body group and repeats; otherwise it reports ready to its parent. It slots under a seq controller exactly like an enable controller and drives std_reg/std_const-style children.

## Interface
- CNT_WIDTH, 8: width of the iteration counter.
- MAX_ITER, 0: iteration bound. 0 means unbounded; otherwise the loop exits after MAX_ITER body completions even if the condition is still 1.

- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces all state to reset values immediately.
- valid  input  1  parent enable; starts the loop when sampled high in IDLE.
- ready  output  1  loop finished; high only in DONE.
- valid_cond  output  1  enable for the condition group; high only in COND.
- ready_cond  input  1  condition group finished; cond_in is valid when this is high.
- cond_in  input  1  condition result, sampled on the edge where ready_cond=1 in COND.
- valid_body  output  1  enable for the body group; high only in BODY.
- ready_body  input  1  body group finished.
- iter_count  output  CNT_WIDTH  number of completed body executions in the current or last run.
- overflow  output  1  last run was terminated by MAX_ITER rather than by cond_in=0.

## Operation
- State register is 2 bits: IDLE=0, COND=1, BODY=2, DONE=3. The encoding is fixed.
- Outputs are Moore outputs decoded from state only:
  - IDLE: all handshake outputs 0.
  - COND: valid_cond=1.
  - BODY: valid_body=1.
  - DONE: ready=1.
- IDLE
  - valid=1: next state COND; iter_count<=0; overflow<=0.
  - otherwise: stay in IDLE.
- COND
  - ready_cond=0: stay in COND.
  - ready_cond=1, cond_in=0: go to DONE.
  - ready_cond=1, cond_in=1, MAX_ITER!=0 and iter_count==MAX_ITER: go to DONE; overflow<=1.
  - ready_cond=1, cond_in=1, otherwise: go to BODY.
- BODY
  - ready_body=0: stay in BODY.
  - ready_body=1: go to COND; iter_count<=iter_count+1.
  - The increment is modulo 2^CNT_WIDTH. Wrap is legal only when MAX_ITER=0.
  - MAX_ITER must be below 2^CNT_WIDTH; it is a parameter error otherwise.
- DONE
  - valid=1: stay in DONE with ready=1.
  - valid=0: go to IDLE.
  - ready is therefore high for at least one cycle even if valid already fell.
- Deassertion of valid in COND or BODY is ignored. The loop runs to completion, since children are never aborted mid-handshake.
- Unused encodings do not occur; the default branch decodes as IDLE and next state is IDLE.
- iter_count and overflow hold their values through DONE and IDLE until the next start.

## Timing
- Reset (reset=0, asynchronous):
  - state=IDLE, iter_count=0, overflow=0.
  - ready, valid_cond and valid_body all 0 within the same cycle.
- Reset release is synchronised externally; the first edge after release may start a run.
- Start latency: valid sampled at edge N puts valid_cond high in cycle N+1.
- Condition result:
  - A result seen at edge M deasserts valid_cond in cycle M+1.
  - In cycle M+1, valid_body or ready is high. There is never an overlap between the two child enables.
- Minimum round trip per iteration is 2 cycles (COND 1 cycle + BODY 1 cycle) when children answer combinationally.
- Minimum zero-iteration run is valid-to-ready in 2 edges.
- Children must drop their ready once their valid falls. The controller never samples ready_cond outside COND or ready_body outside BODY.
- cond_in is ignored whenever ready_cond=0.

## Test plan
- Zero iterations, MAX_ITER=0:
  - Stimulus: valid=1 at edge 1; ready_cond=1, cond_in=0 on first COND cycle.
  - Response: ready=1 in cycle 3, iter_count=0, overflow=0, valid_body never asserted.
- Three iterations with stalls:
  - Stimulus: cond_in=1,1,1,0; each child delays ready by 2 cycles.
  - Response: exactly 3 valid_body pulses ending on ready_body, iter_count=3, overflow=0, ready held while valid=1, IDLE one cycle after valid=0.
- Bound hit, MAX_ITER=2:
  - Stimulus: cond_in always 1.
  - Response: 2 body executions, then DONE with iter_count=2, overflow=1; third cond result not acted on.
- Counter wrap, CNT_WIDTH=2, MAX_ITER=0:
  - Stimulus: 5 iterations then cond_in=0.
  - Response: iter_count=1, overflow=0.
- Async reset mid-BODY:
  - Stimulus: reset=0 between edges during iteration 2.
  - Response: valid_body=0 immediately, iter_count=0, state IDLE.
  - Follow-up: after release, a new valid starts a clean run from iter_count=0.
- Early valid drop:
  - Stimulus: valid=1 for one cycle only; loop of 1 iteration.
  - Response: run completes, ready=1 for exactly one cycle, then IDLE with iter_count=1.
